// File: rtl/uart_frame_tx.sv
// uart_frame_tx: buffers host payload bytes in a FIFO and, on send, emits
// one frame (HEAD0, HEAD1, LEN, payload[, checksum]) through the
// transceiver byte handshake.
// Optional macro: UART_FRAME_CKSUM_EN appends a sum-mod-256 checksum byte
// covering LEN and the payload.
//
// state  | meaning
// S_IDLE | waiting for send with at least one byte buffered
// S_H0   | first header byte
// S_H1   | second header byte
// S_LEN  | length byte
// S_PAY  | payload bytes, one FIFO pop per issue
// S_CKS  | checksum byte (UART_FRAME_CKSUM_EN only)
//
// Each non-idle state has two phases: issue (waiting=0, strobe once the
// transceiver is free) and wait (waiting=1, hold until uart_tx_over).
module uart_frame_tx #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] HEAD0      = 8'hEB,
  parameter logic [7:0] HEAD1      = 8'h90
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_en,
  output logic                          wr_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          send,
  output logic                          frame_busy,
  output logic                          frame_done,
  output logic [7:0]                    uart_tx_data,
  output logic                          uart_tx_data_ready,
  input  logic                          uart_tx_status,
  input  logic                          uart_tx_over
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H0,
    S_H1,
    S_LEN,
    S_PAY
`ifdef UART_FRAME_CKSUM_EN
    , S_CKS
`endif
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop;
  logic [CW-1:0] eff_count;

  state_t        state, state_n;
  logic          waiting, waiting_n;
  logic [CW-1:0] rem_q, rem_n;
  logic [7:0]    tx_data_n;
  logic          tx_ready_n;
  logic          busy_n;
  logic          done_n;
  logic          last_over;
`ifdef UART_FRAME_CKSUM_EN
  logic [7:0]    cks_q, cks_n;
`endif

  // Pushes are refused while a frame is in flight so LEN stays consistent.
  assign push_ok    = wr_en && (count != CW'(FIFO_DEPTH)) && !frame_busy;
  assign eff_count  = count + CW'(push_ok);
  assign fifo_count = count;

  // Payload FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
    end
  end

  // Dropped-push indication, one cycle after the attempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err <= 1'b0;
    else        wr_err <= wr_en && !push_ok;
  end

  // Frame sequencing, then issue of the byte belonging to the next state.
  // Issuing from the next state lets a strobe follow send or uart_tx_over
  // by one cycle.
  always_comb begin
    state_n    = state;
    waiting_n  = waiting;
    rem_n      = rem_q;
    tx_data_n  = uart_tx_data;
    tx_ready_n = 1'b0;
    busy_n     = frame_busy;
    done_n     = 1'b0;
    pop        = 1'b0;
    last_over  = 1'b0;
`ifdef UART_FRAME_CKSUM_EN
    cks_n      = cks_q;
`endif

    case (state)
      S_IDLE: begin
        if (send && (eff_count != '0)) begin
          state_n   = S_H0;
          waiting_n = 1'b0;
          rem_n     = eff_count;
          busy_n    = 1'b1;
`ifdef UART_FRAME_CKSUM_EN
          cks_n     = 8'h00;
`endif
        end
      end
      default: begin
        if (waiting && uart_tx_over) begin
          waiting_n = 1'b0;
          case (state)
            S_H0:  state_n = S_H1;
            S_H1:  state_n = S_LEN;
            S_LEN: state_n = S_PAY;
            S_PAY: begin
              if (rem_q == '0) begin
`ifdef UART_FRAME_CKSUM_EN
                state_n = S_CKS;
`else
                last_over = 1'b1;
`endif
              end
            end
`ifdef UART_FRAME_CKSUM_EN
            S_CKS: last_over = 1'b1;
`endif
            default: state_n = S_IDLE;
          endcase
        end
      end
    endcase

    if (last_over) begin
      state_n = S_IDLE;
      busy_n  = 1'b0;
      done_n  = 1'b1;
    end

    // The registered-strobe check keeps the strobe from ever lasting two cycles.
    if ((state_n != S_IDLE) && !waiting_n && !uart_tx_status && !uart_tx_data_ready) begin
      tx_ready_n = 1'b1;
      waiting_n  = 1'b1;
      case (state_n)
        S_H0: tx_data_n = HEAD0;
        S_H1: tx_data_n = HEAD1;
        S_LEN: begin
          tx_data_n = 8'(rem_n);
`ifdef UART_FRAME_CKSUM_EN
          cks_n     = cks_n + 8'(rem_n);
`endif
        end
        S_PAY: begin
          tx_data_n = mem[rd_ptr];
          pop       = 1'b1;
          rem_n     = rem_n - CW'(1);
`ifdef UART_FRAME_CKSUM_EN
          cks_n     = cks_n + mem[rd_ptr];
`endif
        end
`ifdef UART_FRAME_CKSUM_EN
        S_CKS: tx_data_n = cks_n;
`endif
        default: tx_data_n = uart_tx_data;
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      waiting            <= 1'b0;
      rem_q              <= '0;
      uart_tx_data       <= 8'h00;
      uart_tx_data_ready <= 1'b0;
      frame_busy         <= 1'b0;
      frame_done         <= 1'b0;
`ifdef UART_FRAME_CKSUM_EN
      cks_q              <= 8'h00;
`endif
    end else begin
      state              <= state_n;
      waiting            <= waiting_n;
      rem_q              <= rem_n;
      uart_tx_data       <= tx_data_n;
      uart_tx_data_ready <= tx_ready_n;
      frame_busy         <= busy_n;
      frame_done         <= done_n;
`ifdef UART_FRAME_CKSUM_EN
      cks_q              <= cks_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx: frame-level reference model plus a per-cycle
// compare in tick(), with literal frame contents checked after each test.
module tb_uart_frame_tx;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef logic [7:0] bq_t [$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_en = 1'b0;
  logic          send = 1'b0;
  logic          uart_tx_status = 1'b0;
  logic          uart_tx_over = 1'b0;
  logic          wr_err;
  logic [CW-1:0] fifo_count;
  logic          frame_busy;
  logic          frame_done;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_data_ready;

  uart_frame_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .wr_data            (wr_data),
    .wr_en              (wr_en),
    .wr_err             (wr_err),
    .fifo_count         (fifo_count),
    .send               (send),
    .frame_busy         (frame_busy),
    .frame_done         (frame_done),
    .uart_tx_data       (uart_tx_data),
    .uart_tx_data_ready (uart_tx_data_ready),
    .uart_tx_status     (uart_tx_status),
    .uart_tx_over       (uart_tx_over)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Frame-level model state (written only by the posedge model).
  logic [7:0] mdl_fifo [$];
  int         push_cnt;
  bit         mdl_busy, mdl_done, mdl_err;
  int         overs_left;
  logic [7:0] exp_buf [0:1023];
  bit         exp_pay [0:1023];
  int         exp_wr;
  bit         stat_at_edge;
  int         eff;
  bit         push_acc, send_acc;
  logic [7:0] sum;

  // Compare-side state (written only by the stimulus process via tick()).
  int         pop_cnt = 0;
  int         exp_rd = 0;
  int         cd = 0;
  int         done_cnt = 0;
  logic [7:0] last_data = 8'h00;
  bit         prev_ready = 1'b0;
  logic [7:0] cap [$];
  bq_t        lit;

  // Reference model: applies the frame rules to the inputs seen at each edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      push_cnt = 0; mdl_fifo.delete(); mdl_busy = 0; mdl_done = 0; mdl_err = 0;
      overs_left = 0; exp_wr = 0; stat_at_edge = 0;
    end else begin
      stat_at_edge = uart_tx_status;
      push_acc = wr_en && ((push_cnt - pop_cnt) < DEPTH) && !mdl_busy;
      eff      = push_cnt - pop_cnt + (push_acc ? 1 : 0);
      send_acc = send && !mdl_busy && (eff >= 1);
      mdl_err  = wr_en && !push_acc;
      mdl_done = 0;
      if (push_acc) begin
        mdl_fifo.push_back(wr_data);
        push_cnt++;
      end
      if (mdl_busy && uart_tx_over) begin
        overs_left--;
        if (overs_left == 0) begin
          mdl_busy = 0;
          mdl_done = 1;
        end
      end
      if (send_acc) begin
        sum = 8'(eff);
        exp_buf[exp_wr] = 8'hEB;    exp_pay[exp_wr] = 0; exp_wr++;
        exp_buf[exp_wr] = 8'h90;    exp_pay[exp_wr] = 0; exp_wr++;
        exp_buf[exp_wr] = 8'(eff);  exp_pay[exp_wr] = 0; exp_wr++;
        foreach (mdl_fifo[i]) begin
          exp_buf[exp_wr] = mdl_fifo[i]; exp_pay[exp_wr] = 1; exp_wr++;
          sum = sum + mdl_fifo[i];
        end
`ifdef UART_FRAME_CKSUM_EN
        exp_buf[exp_wr] = sum; exp_pay[exp_wr] = 0; exp_wr++;
        overs_left = eff + 4;
`else
        overs_left = eff + 3;
`endif
        mdl_fifo.delete();
        mdl_busy = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: compare outputs at the falling edge, then drive the
  // transceiver model (uart_tx_over three cycles after each strobe).
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      pop_cnt = 0; exp_rd = 0; cd = 0; uart_tx_over = 1'b0;
      last_data = 8'h00; prev_ready = 1'b0;
      return;
    end
    uart_tx_over = 1'b0;
    if (uart_tx_data_ready) begin
      chk("no_back_to_back", 32'(prev_ready), 0);
      chk("issue_status_low", 32'(stat_at_edge), 0);
      chk("busy_at_issue", 32'(frame_busy), 1);
      chk("byte_expected", 32'(exp_rd < exp_wr), 1);
      if (exp_rd < exp_wr) begin
        chk($sformatf("tx_byte%0d", exp_rd), 32'(uart_tx_data), 32'(exp_buf[exp_rd]));
        if (exp_pay[exp_rd]) pop_cnt++;
        exp_rd++;
      end
      cap.push_back(uart_tx_data);
      last_data = uart_tx_data;
      cd = 3;
    end else begin
      chk("data_hold", 32'(uart_tx_data), 32'(last_data));
      if (cd > 0) begin
        cd--;
        if (cd == 0) uart_tx_over = 1'b1;
      end
    end
    chk("fifo_count", 32'(fifo_count), push_cnt - pop_cnt);
    chk("frame_busy", 32'(frame_busy), 32'(mdl_busy));
    chk("frame_done", 32'(frame_done), 32'(mdl_done));
    chk("wr_err", 32'(wr_err), 32'(mdl_err));
    if (frame_done) begin
      done_cnt++;
      chk("frame_complete", exp_rd, exp_wr);
    end
    prev_ready = uart_tx_data_ready;
  endtask

  task automatic push(input logic [7:0] b);
    wr_data = b; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_send();
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 2000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({name, "_single_done"}, done_cnt - start, 1);
  endtask

  task automatic check_frame(input string name, input int base, input bq_t l);
    chk({name, "_len"}, cap.size() - base, l.size());
    for (int i = 0; i < l.size(); i++)
      if (base + i < cap.size())
        chk($sformatf("%s_b%0d", name, i), 32'(cap[base + i]), 32'(l[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_err"},     32'(wr_err), 0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 0);
    chk({tag, "_busy"},       32'(frame_busy), 0);
    chk({tag, "_done"},       32'(frame_done), 0);
    chk({tag, "_data"},       32'(uart_tx_data), 0);
    chk({tag, "_ready"},      32'(uart_tx_data_ready), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int d0;
    int n;

    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Basic frame.
    base = cap.size();
    push(8'h01); push(8'h02); push(8'h03);
    pulse_send();
    wait_done("basic");
    lit = '{8'hEB, 8'h90, 8'h03, 8'h01, 8'h02, 8'h03};
`ifdef UART_FRAME_CKSUM_EN
    lit.push_back(8'h09);
`endif
    check_frame("basic", base, lit);
    chk("basic_fifo_empty", 32'(fifo_count), 0);

    // Checksum wrap.
    base = cap.size();
    push(8'hFF); push(8'hFF);
    pulse_send();
    wait_done("wrap");
    lit = '{8'hEB, 8'h90, 8'h02, 8'hFF, 8'hFF};
`ifdef UART_FRAME_CKSUM_EN
    lit.push_back(8'h00);
`endif
    check_frame("wrap", base, lit);

    // Full FIFO: the seventeenth push is dropped.
    base = cap.size();
    for (int i = 0; i <= DEPTH; i++) push(8'(i));
    chk("full_wr_err", 32'(wr_err), 1);
    chk("full_count", 32'(fifo_count), 16);
    tick();
    chk("full_wr_err_pulse", 32'(wr_err), 0);
    pulse_send();
    wait_done("full");
    chk("full_len_byte", 32'(cap[base + 2]), 32'h10);
    chk("full_first_pay", 32'(cap[base + 3]), 32'h00);
    chk("full_last_pay", 32'(cap[base + 18]), 32'h0F);
`ifdef UART_FRAME_CKSUM_EN
    chk("full_size", cap.size() - base, 20);
    chk("full_cksum", 32'(cap[base + 19]), 32'h88);
`else
    chk("full_size", cap.size() - base, 19);
`endif

    // Push and send in the same cycle with two bytes buffered.
    base = cap.size();
    push(8'hAA); push(8'hBB);
    wr_data = 8'hCC; wr_en = 1'b1; send = 1'b1;
    tick();
    wr_en = 1'b0; send = 1'b0;
    wait_done("pushsend");
    lit = '{8'hEB, 8'h90, 8'h03, 8'hAA, 8'hBB, 8'hCC};
`ifdef UART_FRAME_CKSUM_EN
    lit.push_back(8'h34);
`endif
    check_frame("pushsend", base, lit);

    // Send with an empty FIFO is ignored.
    base = cap.size();
    pulse_send();
    repeat (5) tick();
    chk("empty_send_busy", 32'(frame_busy), 0);
    chk("empty_send_strobes", cap.size() - base, 0);

    // Push during a frame is dropped.
    base = cap.size();
    push(8'h05);
    pulse_send();
    push(8'h77);
    chk("busy_push_err", 32'(wr_err), 1);
    chk("busy_push_count", 32'(fifo_count), 1);
    wait_done("busypush");
    lit = '{8'hEB, 8'h90, 8'h01, 8'h05};
`ifdef UART_FRAME_CKSUM_EN
    lit.push_back(8'h06);
`endif
    check_frame("busypush", base, lit);

    // Transceiver busy delays the first strobe; then reset during payload.
    base = cap.size();
    push(8'h11); push(8'h22);
    uart_tx_status = 1'b1;
    pulse_send();
    repeat (4) tick();
    chk("hold_busy", 32'(frame_busy), 1);
    chk("hold_no_strobe", cap.size() - base, 0);
    uart_tx_status = 1'b0;
    tick();
    chk("release_strobe", 32'(uart_tx_data_ready), 1);
    chk("release_data", 32'(uart_tx_data), 32'hEB);
    n = 0;
    while (cap.size() < base + 4 && n < 200) begin
      tick();
      n++;
    end
    chk("reach_payload", 32'(cap.size() >= base + 4), 1);
    chk("payload_count", 32'(fifo_count), 1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) tick();
    check_reset_outputs("midrst_hold");
    chk("midrst_no_done", done_cnt - d0, 0);
    rst_n = 1'b1;
    tick();

    // Recovery after reset.
    base = cap.size();
    push(8'h42);
    pulse_send();
    wait_done("recover");
    lit = '{8'hEB, 8'h90, 8'h01, 8'h42};
`ifdef UART_FRAME_CKSUM_EN
    lit.push_back(8'h43);
`endif
    check_frame("recover", base, lit);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Frame builder that sits upstream of `uart_transceiver` on the transmit side. It buffers payload bytes from a host in a small FIFO and, on a send command, emits one frame byte-by-byte through the transceiver's byte handshake (`uart_tx_data` / `uart_tx_data_ready` / `uart_tx_over`). Frame format: header 0xEB, header 0x90, length, payload, optional 8-bit checksum.

## Interface
Parameters:
- `FIFO_DEPTH`, default 16: payload FIFO depth. Must be a power of 2, 2..128; it is also the maximum frame length.
- `HEAD0`, default 8'hEB: first header byte.
- `HEAD1`, default 8'h90: second header byte.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; same clock as `uart_transceiver`.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_data`  in  8  payload byte.
- `wr_en`  in  1  push `wr_data` into the FIFO.
- `wr_err`  out  1  one-cycle pulse when a push is dropped.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO.
- `send`  in  1  request to transmit the buffered bytes as one frame.
- `frame_busy`  out  1  high while a frame is in progress.
- `frame_done`  out  1  one-cycle pulse when the frame is complete.
- `uart_tx_data`  out  8  byte to the transceiver.
- `uart_tx_data_ready`  out  1  one-cycle issue strobe to the transceiver.
- `uart_tx_status`  in  1  transceiver transmit in progress.
- `uart_tx_over`  in  1  transceiver byte-complete pulse.

## Operation
- **Write path**
  - A push is accepted when `wr_en`=1, the FIFO is not full and `frame_busy`=0.
  - A push is dropped, with `wr_err`=1 on the next cycle, if the FIFO is full or `frame_busy`=1. A dropped push leaves `fifo_count` unchanged.
- **Send acceptance**
  - `send` is accepted only in IDLE with effective count ≥1, where effective count = `fifo_count` plus 1 if a push is accepted in the same cycle.
  - The effective count is latched as LEN.
  - `send` with count 0, or while busy, is ignored with no error.
- **Main FSM:** IDLE → H0 → H1 → LEN → PAY → CKS → IDLE.
  - CKS exists only with `UART_FRAME_CKSUM_EN`.
  - PAY repeats LEN times, popping one FIFO byte per issue.
- **Per-byte sub-phase:** ISSUE → WAIT.
  - ISSUE holds until `uart_tx_status`=0, then drives `uart_tx_data` and pulses `uart_tx_data_ready` for exactly one cycle.
  - WAIT holds until `uart_tx_over`=1, then advances to the next byte.
- **Checksum:** an 8-bit accumulator, sum mod 256 of the LEN byte and all payload bytes. Headers are excluded. It is cleared at send acceptance.
- After the final byte's `uart_tx_over`, the block returns to IDLE; the FIFO is empty at that point.
- **Reset, including mid-frame:** every register is cleared asynchronously, the FIFO is emptied and the frame is abandoned without `frame_done`. The wire may carry a truncated byte.
- **Reset values:** `wr_err`=0, `fifo_count`=0, `frame_busy`=0, `frame_done`=0, `uart_tx_data`=8'h00, `uart_tx_data_ready`=0.

## Timing
- All outputs are registered.
- `send` accepted at cycle N: `frame_busy`=1, `uart_tx_data`=HEAD0 and `uart_tx_data_ready`=1 at N+1, provided `uart_tx_status`=0.
- `uart_tx_over` sampled at cycle M: the next byte's strobe comes at M+1 at the earliest.
- Last byte's `uart_tx_over` at cycle M: `frame_done`=1 and `frame_busy`=0 at M+1, and a new `send` can be accepted at M+1.
- `uart_tx_data` holds its value from the issue cycle until the next issue.
- `uart_tx_data_ready` is never high on two consecutive cycles.
- `fifo_count` updates the cycle after an accepted push. It decrements the cycle after each payload issue.

## Configuration
- `UART_FRAME_CKSUM_EN` defined: the CKS state appends the checksum byte after the payload. Frame length on the wire = LEN+4.
- `UART_FRAME_CKSUM_EN` undefined: no CKS state and no accumulator. The frame ends after the last payload byte. Frame length on the wire = LEN+3.

## Test plan
- **Basic frame:** push 01 02 03, then `send`; model `uart_tx_over` 3 cycles after each strobe.
  - With `UART_FRAME_CKSUM_EN`: bytes EB 90 03 01 02 03 09, then a single `frame_done`.
  - Without it: EB 90 03 01 02 03.
- **Checksum wrap:** push FF FF, then `send` → EB 90 02 FF FF 00 (0x200 mod 256).
- **Full FIFO:** 17 pushes at depth 16 → 17th gives `wr_err`=1, `fifo_count`=16, LEN byte 0x10.
- **Push and send together:** push with `send` in the same cycle and the FIFO holding 2 bytes → LEN=03, and the new byte is transmitted last.
- **Illegal requests:** `send` with the FIFO empty → no strobe, `frame_busy` stays 0. Push during a frame → `wr_err` pulse, `fifo_count` unchanged.
- **Handshake and reset:** hold `uart_tx_status`=1 at issue → strobe is delayed until it falls. Then assert `rst_n`=0 during PAY → all outputs return to reset values immediately, `fifo_count`=0, no `frame_done`.
